// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
// Sequences decode operand reads and write-back requests onto a dual-read /
// single-write register file with one-cycle registered read data. Writes take
// priority over reads. Writes to the PC index are turned into a one-cycle
// redirect strobe, because the register file does not hold the PC.
module regfile_access_ctrl #(
    parameter int DW      = 32,
    parameter int AW      = 4,
    parameter int PC_ADDR = 15
) (
    input  logic          clk,
    input  logic          reset,
    // operand read request from decode
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [AW-1:0] op_ra,
    input  logic [AW-1:0] op_rb,
    // operand response
    output logic          opd_valid,
    input  logic          opd_ready,
    output logic [DW-1:0] opd_a,
    output logic [DW-1:0] opd_b,
    // write-back request
    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    // register file port
    output logic [AW-1:0] rf_a1,
    output logic [AW-1:0] rf_a2,
    output logic [AW-1:0] rf_a3,
    output logic [DW-1:0] rf_wd3,
    output logic          rf_we3,
    input  logic [DW-1:0] rf_rd1,
    input  logic [DW-1:0] rf_rd2,
    // PC redirect
    output logic          pc_wr_valid,
    output logic [DW-1:0] pc_wr_data
);

    localparam logic [AW-1:0] PC_IDX = AW'(PC_ADDR);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ra_q, ra_d;
    logic [AW-1:0] rb_q, rb_d;
    logic          opd_valid_q, opd_valid_d;
    logic [DW-1:0] opd_a_q, opd_a_d;
    logic [DW-1:0] opd_b_q, opd_b_d;
    logic          pc_valid_q, pc_valid_d;
    logic [DW-1:0] pc_data_q, pc_data_d;

    logic wb_fire;
    logic wr_cycle;
    logic pc_cycle;
    logic rd_issue;

    // Write-back handshake decode; PC writes never reach the register file.
    assign wb_ready = (state_q != RD_WAIT);
    assign wb_fire  = wb_valid & wb_ready;
    assign wr_cycle = wb_fire & (wb_addr != PC_IDX);
    assign pc_cycle = wb_fire & (wb_addr == PC_IDX);

    // A read may only issue in IDLE on a cycle with no pending write-back.
    assign op_ready = (state_q == IDLE) & ~wb_valid;
    assign rd_issue = op_valid & op_ready;

    // Register file port drive. rf_a1 doubles as the write-qualifying address
    // during a write cycle; otherwise both read ports show the issuing or
    // latched read addresses. rf_we3 is held low while in reset.
    assign rf_we3 = wr_cycle & ~reset;
    assign rf_a3  = wb_addr;
    assign rf_wd3 = wb_data;
    assign rf_a1  = wr_cycle ? wb_addr : (rd_issue ? op_ra : ra_q);
    assign rf_a2  = rd_issue ? op_rb : rb_q;

    assign opd_valid   = opd_valid_q;
    assign opd_a       = opd_a_q;
    assign opd_b       = opd_b_q;
    assign pc_wr_valid = pc_valid_q;
    assign pc_wr_data  = pc_data_q;

    // Next-state logic: read sequencing, operand capture and PC strobe.
    always_comb begin
        state_d     = state_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        opd_valid_d = opd_valid_q;
        opd_a_d     = opd_a_q;
        opd_b_d     = opd_b_q;
        pc_valid_d  = 1'b0;
        pc_data_d   = pc_data_q;

        if (pc_cycle) begin
            pc_valid_d = 1'b1;
            pc_data_d  = wb_data;
        end

        unique case (state_q)
            IDLE: begin
                if (rd_issue) begin
                    ra_d    = op_ra;
                    rb_d    = op_rb;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // Read data registered at the end of the issue cycle is
                // present now; capture it into the response registers.
                opd_a_d     = rf_rd1;
                opd_b_d     = rf_rd2;
                opd_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (opd_ready) begin
                    opd_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                opd_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ra_q        <= '0;
            rb_q        <= '0;
            opd_valid_q <= 1'b0;
            opd_a_q     <= '0;
            opd_b_q     <= '0;
            pc_valid_q  <= 1'b0;
            pc_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            opd_valid_q <= opd_valid_d;
            opd_a_q     <= opd_a_d;
            opd_b_q     <= opd_b_d;
            pc_valid_q  <= pc_valid_d;
            pc_data_q   <= pc_data_d;
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural register file
// (registered reads, writes accepted while rf_a1 < 15, index 15 reads the PC).
module tb_regfile_access_ctrl;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam logic [31:0] PC_VAL = 32'h0000_0200;

    logic          clk = 1'b0;
    logic          reset;
    logic          op_valid, op_ready;
    logic [AW-1:0] op_ra, op_rb;
    logic          opd_valid, opd_ready;
    logic [DW-1:0] opd_a, opd_b;
    logic          wb_valid, wb_ready;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] rf_a1, rf_a2, rf_a3;
    logic [DW-1:0] rf_wd3;
    logic          rf_we3;
    logic [DW-1:0] rf_rd1, rf_rd2;
    logic          pc_wr_valid;
    logic [DW-1:0] pc_wr_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] mem [0:15];

    regfile_access_ctrl #(.DW(DW), .AW(AW), .PC_ADDR(15)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_ra(op_ra), .op_rb(op_rb),
        .opd_valid(opd_valid), .opd_ready(opd_ready), .opd_a(opd_a), .opd_b(opd_b),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we3(rf_we3),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .pc_wr_valid(pc_wr_valid), .pc_wr_data(pc_wr_data)
    );

    always #5 clk = ~clk;

    // Register file model.
    always @(posedge clk) begin
        if (rf_we3 && rf_a1 < 4'd15) mem[rf_a3] <= rf_wd3;
        rf_rd1 <= (rf_a1 == 4'd15) ? PC_VAL : mem[rf_a1];
        rf_rd2 <= (rf_a2 == 4'd15) ? PC_VAL : mem[rf_a2];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Back-to-back request table and expected responses.
    logic [AW-1:0] bb_ra [0:2];
    logic [AW-1:0] bb_rb [0:2];
    logic [DW-1:0] bb_ea [0:2];
    logic [DW-1:0] bb_eb [0:2];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        bb_ra[0] = 4'd3; bb_rb[0] = 4'd2;  bb_ea[0] = 32'hDEADBEEF; bb_eb[0] = 32'd7;
        bb_ra[1] = 4'd1; bb_rb[1] = 4'd15; bb_ea[1] = 32'd5;        bb_eb[1] = PC_VAL;
        bb_ra[2] = 4'd2; bb_rb[2] = 4'd3;  bb_ea[2] = 32'd7;        bb_eb[2] = 32'hDEADBEEF;

        reset = 1'b1; op_valid = 0; op_ra = 0; op_rb = 0; opd_ready = 0;
        wb_valid = 0; wb_addr = 0; wb_data = 0;

        // ---- reset state
        repeat (2) @(negedge clk);
        check("rst_opd_valid", opd_valid, 0);
        check("rst_opd_a", opd_a, 0);
        check("rst_pc_valid", pc_wr_valid, 0);
        check("rst_pc_data", pc_wr_data, 0);
        check("rst_we3", rf_we3, 0);
        check("rst_a1", rf_a1, 0);
        reset = 1'b0;
        $display("reset released");

        // ---- write r3 then read r3/r0
        wb_valid = 1; wb_addr = 4'd3; wb_data = 32'hDEADBEEF; #1;
        check("w1_we3", rf_we3, 1);
        check("w1_a3", rf_a3, 3);
        check("w1_a1", rf_a1, 3);
        check("w1_wd3", rf_wd3, 32'hDEADBEEF);
        check("w1_op_ready", op_ready, 0);
        @(negedge clk);
        wb_valid = 0; op_valid = 1; op_ra = 4'd3; op_rb = 4'd0; #1;
        check("r1_op_ready", op_ready, 1);
        check("r1_a1", rf_a1, 3);
        check("r1_a2", rf_a2, 0);
        check("r1_we3", rf_we3, 0);
        @(negedge clk);
        op_valid = 0; #1;
        check("r1_wait_wb_ready", wb_ready, 0);
        check("r1_wait_opd_valid", opd_valid, 0);
        check("r1_wait_a1_held", rf_a1, 3);
        @(negedge clk);
        check("r1_opd_valid", opd_valid, 1);
        check("r1_opd_a", opd_a, 32'hDEADBEEF);
        check("r1_opd_b", opd_b, 0);
        opd_ready = 1;
        @(negedge clk);
        opd_ready = 0; #1;
        check("r1_done_valid", opd_valid, 0);
        check("r1_done_op_ready", op_ready, 1);
        $display("write/read r3: opd_a=%h opd_b=%h", 32'hDEADBEEF, 0);

        // ---- PC write
        wb_valid = 1; wb_addr = 4'd15; wb_data = 32'h0000_0100; #1;
        check("pc_we3", rf_we3, 0);
        check("pc_strobe_early", pc_wr_valid, 0);
        @(negedge clk);
        wb_valid = 0;
        check("pc_strobe", pc_wr_valid, 1);
        check("pc_data", pc_wr_data, 32'h100);
        @(negedge clk);
        check("pc_strobe_off", pc_wr_valid, 0);
        check("pc_data_hold", pc_wr_data, 32'h100);
        check("pc_not_in_rf", mem[15], 0);
        $display("pc write 0x100");

        // ---- collision: write r1=5 with read r1/r1
        wb_valid = 1; wb_addr = 4'd1; wb_data = 32'd5;
        op_valid = 1; op_ra = 4'd1; op_rb = 4'd1; #1;
        check("col_op_ready", op_ready, 0);
        check("col_we3", rf_we3, 1);
        @(negedge clk);
        wb_valid = 0; #1;
        check("col_issue", op_ready, 1);
        @(negedge clk);
        op_valid = 0;
        @(negedge clk);
        check("col_opd_valid", opd_valid, 1);
        check("col_opd_a", opd_a, 5);
        check("col_opd_b", opd_b, 5);
        $display("collision r1: opd_a=%h opd_b=%h", 5, 5);

        // ---- backpressure in RESP with write-back r2=7
        wb_valid = 1; wb_addr = 4'd2; wb_data = 32'd7;
        op_valid = 1; op_ra = 4'd0; op_rb = 4'd0; #1;
        check("bp_wb_ready", wb_ready, 1);
        check("bp_we3", rf_we3, 1);
        check("bp_op_ready", op_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wb_valid = 0; #1;
            check("bp_hold_valid", opd_valid, 1);
            check("bp_hold_a", opd_a, 5);
            check("bp_hold_b", opd_b, 5);
            check("bp_hold_op_ready", op_ready, 0);
        end
        @(negedge clk);
        op_valid = 0; opd_ready = 1;
        check("bp_last_valid", opd_valid, 1);
        @(negedge clk);
        opd_ready = 0; #1;
        check("bp_release_valid", opd_valid, 0);
        check("bp_release_op_ready", op_ready, 1);
        $display("backpressure: operands held at 5/5");

        // ---- reset during RD_WAIT
        op_valid = 1; op_ra = 4'd1; op_rb = 4'd3;
        @(negedge clk);
        op_valid = 0; reset = 1;
        @(negedge clk);
        reset = 0; #1;
        check("rr_opd_valid", opd_valid, 0);
        check("rr_op_ready", op_ready, 1);
        check("rr_wb_ready", wb_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rr_no_stale", opd_valid, 0);
        end
        $display("reset in RD_WAIT: no response");

        // ---- back-to-back reads with opd_ready held high
        begin
            int idx;
            int ridx;
            idx = 0; ridx = 0;
            opd_ready = 1;
            for (int cyc = 0; cyc < 11; cyc++) begin
                op_valid = (idx < 3);
                op_ra = (idx < 3) ? bb_ra[idx] : 4'd0;
                op_rb = (idx < 3) ? bb_rb[idx] : 4'd0;
                #1;
                check("bb_op_ready", op_ready, (cyc == 0 || cyc == 3 || cyc == 6 || cyc > 8) ? 1 : 0);
                check("bb_opd_valid", opd_valid, (cyc == 2 || cyc == 5 || cyc == 8) ? 1 : 0);
                if (opd_valid === 1'b1 && ridx < 3) begin
                    check("bb_opd_a", opd_a, bb_ea[ridx]);
                    check("bb_opd_b", opd_b, bb_eb[ridx]);
                    $display("b2b resp %0d cyc %0d: a=%h b=%h", ridx, cyc, opd_a, opd_b);
                    ridx++;
                end
                if (op_valid && op_ready) idx++;
                @(negedge clk);
            end
            check("bb_resp_count", ridx, 3);
            op_valid = 0; opd_ready = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Initiator-side controller for the CPU's dual-read / single-write register file.
- Accepts operand-read requests from decode and write-back requests from the execute/memory stage, then sequences them onto the register file's a1/a2/a3/wd3/we3 port.
- Absorbs the register file's one-cycle registered read latency and returns both operands through a valid/ready handshake.
- Diverts writes to register 15 (PC) onto a dedicated PC-update strobe, because the register file does not store the PC.

Parameters:
- DW, 32, data width of registers and operands.
- AW, 4, register address width.
- PC_ADDR, 15, register index aliased to the program counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- op_valid  in  1  operand read request valid.
- op_ready  out  1  controller accepts a read request this cycle.
- op_ra  in  AW  first source register index.
- op_rb  in  AW  second source register index.
- opd_valid  out  1  operand response valid.
- opd_ready  in  1  consumer accepts the response.
- opd_a  out  DW  value of op_ra.
- opd_b  out  DW  value of op_rb.
- wb_valid  in  1  write-back request valid.
- wb_ready  out  1  controller accepts the write-back this cycle.
- wb_addr  in  AW  destination register.
- wb_data  in  DW  write data.
- rf_a1  out  AW  register-file read address 1.
- rf_a2  out  AW  register-file read address 2.
- rf_a3  out  AW  register-file write address.
- rf_wd3  out  DW  register-file write data.
- rf_we3  out  1  register-file write enable.
- rf_rd1  in  DW  register-file read data 1; registered, valid the cycle after a non-write issue cycle.
- rf_rd2  in  DW  register-file read data 2; same timing as rf_rd1.
- pc_wr_valid  out  1  one-cycle PC redirect strobe.
- pc_wr_data  out  DW  new PC value.

Behaviour:
- States: IDLE, RD_WAIT, RESP.
- Reset: state IDLE.
  - Registered outputs all 0: opd_valid, opd_a, opd_b, pc_wr_valid, pc_wr_data, rf_we3.
  - Latched read addresses are 0.
  - Any in-flight read or response is discarded; no PC strobe is produced.
- Write-back arbitration:
  - Write-back has priority over reads in every state.
  - wb_ready = 1 whenever state != RD_WAIT.
  - A write handshake (wb_valid & wb_ready) with wb_addr != PC_ADDR is a register write cycle:
    - rf_we3 = 1, rf_a3 = wb_addr, rf_wd3 = wb_data.
    - rf_a1 = wb_addr. The register file only accepts writes while rf_a1 < PC_ADDR.
  - A write handshake with wb_addr == PC_ADDR:
    - rf_we3 = 0.
    - Next cycle: pc_wr_valid = 1 for exactly one cycle, and pc_wr_data = wb_data.
    - pc_wr_data holds its value afterwards.
  - rf_we3 is combinational from the handshake and is 0 in all other cycles.
- Read issue:
  - op_ready = (state == IDLE) & ~wb_valid.
  - On op_valid & op_ready: latch op_ra/op_rb, drive rf_a1 = op_ra and rf_a2 = op_rb this cycle (rf_we3 = 0), then go to RD_WAIT.
- RD_WAIT (exactly 1 cycle):
  - rf_a1/rf_a2 are held at the latched addresses.
  - rf_we3 = 0 and wb_ready = 0.
  - End of cycle: capture rf_rd1 into opd_a and rf_rd2 into opd_b, set opd_valid = 1, go to RESP.
- RESP:
  - opd_valid, opd_a and opd_b are held stable until opd_ready.
  - On opd_ready: opd_valid drops next cycle and state returns to IDLE.
  - Write-backs are allowed in RESP and do not alter the captured operands.
- Read latency: a request issued in cycle N has opd_valid = 1 in cycle N+2. Maximum throughput is one read per 3 cycles.
- Ordering: a write accepted in cycle N is visible to any read issued in cycle N+1 or later.
- Outside issue, RD_WAIT and write cycles, rf_a1/rf_a2 hold the last latched read addresses.
- Simultaneous wb_valid and op_valid in IDLE: the write is taken, op_ready = 0, and the read issues on a later write-free cycle.
- PC reads (op_ra or op_rb == PC_ADDR) pass through unchanged; the register file supplies the PC value.

Test Plan:
- Write then read:
  - wb r3 = 0xDEADBEEF, then op r3/r0 → rf_we3 pulse with rf_a3 = 3.
  - opd_valid 2 cycles after issue, opd_a = 0xDEADBEEF, opd_b = 0.
- PC write:
  - wb r15 = 0x00000100 → rf_we3 stays 0.
  - Next cycle: pc_wr_valid = 1 for one cycle, pc_wr_data = 0x100.
- Collision:
  - wb r1 = 5 and op r1/r1 both valid in IDLE → write first (op_ready = 0).
  - Read issues next cycle; opd_a = opd_b = 5.
- Backpressure:
  - opd_ready held 0 for 4 cycles while wb r2 = 7 is accepted in RESP → opd_a/opd_b unchanged.
  - op_ready = 0 until the response is accepted.
- Reset mid-read:
  - Assert reset in RD_WAIT → next cycle opd_valid = 0, state IDLE, op_ready = 1.
  - No stale response follows.
- Back-to-back reads: three ops → responses in cycles N+2, N+5, N+8 with correct data order.
